force_cache_writer: RTL and testbench
=====================================

FORCE_CACHE_WRITER -- requirements
Module: force_cache_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of one force component; two's-complement fixed point.
REQ-002 Parameter PARTICLE_ID_WIDTH, default 7: cache depth is 2^PARTICLE_ID_WIDTH entries.
REQ-003 Parameter NUM_FILTER, default 7: number of force-buffer input channels.
REQ-004 Parameter FORCE_BUFFER_WIDTH, default 3*DATA_WIDTH+PARTICLE_ID_WIDTH+1: width of one channel entry.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset; synchronous, active-low.
REQ-007 force_data_in  in  NUM_FILTER*FORCE_BUFFER_WIDTH  channel i occupies bits [(i+1)*FORCE_BUFFER_WIDTH-1 : i*FORCE_BUFFER_WIDTH]; show-ahead buffer heads.
REQ-008 input_force_valid  in  NUM_FILTER  channel i head entry valid.
REQ-009 write_success  out  NUM_FILTER  one-hot pop to channel i; combinational.
REQ-010 clear  in  1  single-cycle pulse requesting a zero-fill of the cache.
REQ-011 rd_en  in  1  readout request.
REQ-012 rd_addr  in  PARTICLE_ID_WIDTH  readout address.
REQ-013 rd_data  out  3*DATA_WIDTH  {fx,fy,fz}, fx in MSBs.
REQ-014 rd_valid  out  1  rd_data valid.
REQ-015 busy  out  1  high in CLEAR or while the accumulate pipeline is non-empty.

Function
REQ-016 Channel entry layout, MSB to LSB: tag (1 bit), fx, fy, fz (DATA_WIDTH each), particle id (PARTICLE_ID_WIDTH).
REQ-017 FSM states: ACCUM (post-reset) and CLEAR.
REQ-018 Grant in cycle t only if all hold: state ACCUM; rd_en low; no clear accepted in t; at least one input_force_valid bit set.
REQ-019 Arbitration: round-robin; pointer resets to 0; channels scanned from pointer upward with wrap; after a grant to g, pointer = (g+1) mod NUM_FILTER.
REQ-020 On a grant to g, write_success[g]=1 in the same cycle; all other bits 0; at most one bit set in any cycle.
REQ-021 Stage A (cycle t): latch granted entry; issue cache read at the entry id.
REQ-022 Stage B (cycle t+1): each component = old component + entry component, modulo 2^DATA_WIDTH (wrap, no saturation); result written to the cache at that id.
REQ-023 Tag=0 entries are popped and pass through both stages without a cache write.
REQ-024 Forwarding: when stage B writes id k in cycle t+1 and stage A reads id k in cycle t+1, the next stage B uses the value written at t+1, not the stale read data; consecutive updates to one id never lose a contribution.
REQ-025 Readout: rd_en in cycle t returns rd_data with rd_valid=1 in t+1; rd_valid=0 in every other cycle.
REQ-026 Readout ordering: a read issued while a stage B write to the same address is in flight returns the post-write value.
REQ-027 rd_en has priority over grants; a cycle with rd_en high issues no grant.
REQ-028 clear is accepted in ACCUM only when stage B is empty; if stage B is full, acceptance waits one cycle, with the request held internally.
REQ-029 Accepting clear moves the FSM to CLEAR; one address zeroed per cycle, 0 to 2^PARTICLE_ID_WIDTH-1; after the last address the FSM returns to ACCUM.
REQ-030 In CLEAR: no grants; rd_en ignored (rd_valid stays 0); further clear pulses ignored.
REQ-031 busy=1 throughout CLEAR and in any cycle where stage A or stage B holds an entry.

Reset
REQ-032 With rst=0 at a clock edge, the following reset: state ACCUM, round-robin pointer 0, pipeline empty, pending clear dropped, write_success=0, rd_valid=0, rd_data=0, busy=0.
REQ-033 Cache contents are not reset and are undefined until a clear completes.
REQ-034 rst asserted mid-CLEAR or mid-accumulate aborts the operation at once; no further cache writes occur.

Verification
REQ-035 Reset then clear; after busy falls, read all 128 addresses -> each rd_data=0, rd_valid exactly one cycle after each rd_en.
REQ-036 Channels 0, 3 and 6 continuously valid, each entry id 5, force (1,2,3) -> grant order 0,3,6,0,...; after 30 pops, address 5 reads (30,60,90).
REQ-037 Channel 2 sends id 9 with fx=7 on 10 consecutive grants (forwarding stress) -> address 9 fx=70.
REQ-038 fx=0x7FFFFFFF accumulated with fx=1 -> 0x80000000 (wrap).
REQ-039 Channel valid with tag=0 -> popped (write_success pulse), target address unchanged; rd_en held high with all channels valid -> write_success=0 every such cycle.
REQ-040 clear pulsed while stage B full -> CLEAR entered one cycle late; rst=0 mid-CLEAR -> FSM in ACCUM, busy=0 on the next cycle.

Source files
------------

// File: rtl/force_cache_writer.sv
// force_cache_writer
// Accumulates 3-component force contributions from several show-ahead force
// buffers into a per-particle force cache, and supports readout and a
// sequential zero-fill of the whole cache.
//
// Ports:
//   clk               - single clock, rising edge
//   rst               - synchronous, active-low reset
//   force_data_in     - NUM_FILTER channel heads, {tag, fx, fy, fz, id} each
//   input_force_valid - per-channel head valid
//   write_success     - one-hot pop of the granted channel (same cycle)
//   clear             - single-cycle request to zero-fill the cache
//   rd_en / rd_addr   - readout request and address
//   rd_data           - {fx, fy, fz}, valid one cycle after rd_en
//   rd_valid          - rd_data qualifier
//   busy              - clearing, or an entry is in the accumulate pipeline
module force_cache_writer #(
  parameter int DATA_WIDTH         = 32,
  parameter int PARTICLE_ID_WIDTH  = 7,
  parameter int NUM_FILTER         = 7,
  parameter int FORCE_BUFFER_WIDTH = 3*DATA_WIDTH+PARTICLE_ID_WIDTH+1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_FILTER*FORCE_BUFFER_WIDTH-1:0] force_data_in,
  input  logic [NUM_FILTER-1:0]                    input_force_valid,
  output logic [NUM_FILTER-1:0]                    write_success,
  input  logic                                     clear,
  input  logic                                     rd_en,
  input  logic [PARTICLE_ID_WIDTH-1:0]             rd_addr,
  output logic [3*DATA_WIDTH-1:0]                  rd_data,
  output logic                                     rd_valid,
  output logic                                     busy
);

  localparam int FW    = 3*DATA_WIDTH;
  localparam int DEPTH = 1 << PARTICLE_ID_WIDTH;
  localparam int PTR_W = (NUM_FILTER > 1) ? $clog2(NUM_FILTER) : 1;

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Component-wise wrapping add of two packed {fx, fy, fz} vectors.
  function automatic logic [FW-1:0] add3(input logic [FW-1:0] a, input logic [FW-1:0] b);
    logic [FW-1:0] r;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      r[c*DATA_WIDTH +: DATA_WIDTH] = a[c*DATA_WIDTH +: DATA_WIDTH] + b[c*DATA_WIDTH +: DATA_WIDTH];
    end
    return r;
  endfunction

  logic [FW-1:0]                cache_r [DEPTH];
  logic [0:0]                   state_r;
  logic [PTR_W-1:0]             ptr_r;
  logic                         pending_r;
  logic [PARTICLE_ID_WIDTH-1:0] clr_addr_r;
  logic                         b_valid_r;
  logic                         b_tag_r;
  logic [FW-1:0]                b_force_r;
  logic [PARTICLE_ID_WIDTH-1:0] b_id_r;
  logic [FW-1:0]                rdq_r;
  logic                         rd_valid_r;

  logic                         grant_found_s;
  logic [PTR_W-1:0]             grant_idx_s;
  logic [PTR_W-1:0]             scan_idx_s;
  logic [FORCE_BUFFER_WIDTH-1:0] entry_s;
  logic                         entry_tag_s;
  logic [FW-1:0]                entry_force_s;
  logic [PARTICLE_ID_WIDTH-1:0] entry_id_s;
  logic                         accum_s;
  logic                         clr_req_s;
  logic                         clr_accept_s;
  logic                         grant_s;
  logic                         rd_issue_s;
  logic                         b_write_s;
  logic [FW-1:0]                sum_s;
  logic [PARTICLE_ID_WIDTH-1:0] raddr_s;
  logic                         bypass_s;
  logic [PTR_W-1:0]             ptr_next_s;

  // Round-robin scan: first valid channel at or above the pointer, with wrap.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    scan_idx_s    = ptr_r;
    for (int k = 0; k < NUM_FILTER; k++) begin
      if (!grant_found_s && input_force_valid[scan_idx_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = scan_idx_s;
      end else begin
        grant_found_s = grant_found_s;
      end
      if (scan_idx_s == PTR_W'(NUM_FILTER-1)) begin
        scan_idx_s = '0;
      end else begin
        scan_idx_s = scan_idx_s + PTR_W'(1);
      end
    end
  end

  // Select the granted channel's head entry.
  always_comb begin
    entry_s = '0;
    for (int i = 0; i < NUM_FILTER; i++) begin
      if (grant_idx_s == PTR_W'(i)) begin
        entry_s = force_data_in[i*FORCE_BUFFER_WIDTH +: FORCE_BUFFER_WIDTH];
      end else begin
        entry_s = entry_s;
      end
    end
  end

  assign entry_tag_s   = entry_s[FORCE_BUFFER_WIDTH-1];
  assign entry_force_s = entry_s[FORCE_BUFFER_WIDTH-2 -: FW];
  assign entry_id_s    = entry_s[PARTICLE_ID_WIDTH-1:0];

  // Grant, read-port and clear-acceptance control.
  always_comb begin
    accum_s      = rst && (state_r == ST_ACCUM);
    clr_req_s    = clear || pending_r;
    // A clear request also holds off grants, so stage B is guaranteed empty
    // on the following cycle and a deferred clear waits exactly one cycle.
    clr_accept_s = accum_s && clr_req_s && !b_valid_r;
    grant_s      = accum_s && !rd_en && !clr_req_s && grant_found_s;
    rd_issue_s   = accum_s && rd_en;
    b_write_s    = b_valid_r && b_tag_r;
    sum_s        = add3(rdq_r, b_force_r);
    raddr_s      = rd_en ? rd_addr : entry_id_s;
    // Stage B's write lands on the same edge as this read; take the new value.
    bypass_s     = b_write_s && (b_id_r == raddr_s);
    if (grant_idx_s == PTR_W'(NUM_FILTER-1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = grant_idx_s + PTR_W'(1);
    end
  end

  // One-hot pop strobe for the granted channel.
  always_comb begin
    write_success = '0;
    if (grant_s) begin
      write_success = NUM_FILTER'(1) << grant_idx_s;
    end else begin
      write_success = '0;
    end
  end

  // Cache write port: zero-fill while clearing, otherwise stage B results.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // Cache contents are intentionally left untouched by reset.
    end else if (state_r == ST_CLEAR) begin
      cache_r[clr_addr_r] <= '0;
    end else if (b_write_s) begin
      cache_r[b_id_r] <= sum_s;
    end
  end

  // Pipeline, arbitration pointer, read register and clear FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_ACCUM;
      ptr_r      <= '0;
      pending_r  <= 1'b0;
      clr_addr_r <= '0;
      b_valid_r  <= 1'b0;
      b_tag_r    <= 1'b0;
      b_force_r  <= '0;
      b_id_r     <= '0;
      rdq_r      <= '0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_issue_s;
      b_valid_r  <= grant_s;
      if (grant_s) begin
        b_tag_r   <= entry_tag_s;
        b_force_r <= entry_force_s;
        b_id_r    <= entry_id_s;
        ptr_r     <= ptr_next_s;
      end
      if (grant_s || rd_issue_s) begin
        rdq_r <= bypass_s ? sum_s : cache_r[raddr_s];
      end
      case (state_r)
        ST_ACCUM: begin
          clr_addr_r <= '0;
          if (clr_accept_s) begin
            state_r   <= ST_CLEAR;
            pending_r <= 1'b0;
          end else if (clear) begin
            pending_r <= 1'b1;
          end
        end
        ST_CLEAR: begin
          pending_r  <= 1'b0;
          clr_addr_r <= clr_addr_r + PARTICLE_ID_WIDTH'(1);
          if (clr_addr_r == {PARTICLE_ID_WIDTH{1'b1}}) begin
            state_r <= ST_ACCUM;
          end
        end
        default: begin
          state_r <= ST_ACCUM;
        end
      endcase
    end
  end

  assign rd_data  = rdq_r;
  assign rd_valid = rd_valid_r;
  assign busy     = (state_r == ST_CLEAR) || b_valid_r || grant_s;

endmodule

// File: tb/tb_force_cache_writer.sv
// Self-checking bench for force_cache_writer: directed scenarios plus random
// traffic against a behavioural cache model, with a scoreboard for readout.
module tb_force_cache_writer;

  localparam int DW    = 32;
  localparam int IW    = 7;
  localparam int NF    = 7;
  localparam int FBW   = 3*DW+IW+1;
  localparam int DEPTH = 1 << IW;

  logic              clk = 1'b0;
  logic              rst;
  logic [NF*FBW-1:0] force_data_in;
  logic [NF-1:0]     input_force_valid;
  logic [NF-1:0]     write_success;
  logic              clear;
  logic              rd_en;
  logic [IW-1:0]     rd_addr;
  logic [3*DW-1:0]   rd_data;
  logic              rd_valid;
  logic              busy;

  force_cache_writer #(
    .DATA_WIDTH(DW), .PARTICLE_ID_WIDTH(IW), .NUM_FILTER(NF), .FORCE_BUFFER_WIDTH(FBW)
  ) dut (
    .clk(clk), .rst(rst), .force_data_in(force_data_in),
    .input_force_valid(input_force_valid), .write_success(write_success),
    .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cache contents and round-robin pointer.
  logic [DW-1:0] mdl [DEPTH][3];
  int            rr_ptr;

  // Channel heads as seen by the DUT.
  logic          ch_tag [NF];
  logic [DW-1:0] ch_f   [NF][3];
  logic [IW-1:0] ch_id  [NF];
  logic [NF-1:0] ch_valid;

  typedef struct { int unsigned cyc; logic [3*DW-1:0] data; } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [3*DW-1:0] act, input logic [3*DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NF; i++) begin
      force_data_in[i*FBW +: FBW] = {ch_tag[i], ch_f[i][0], ch_f[i][1], ch_f[i][2], ch_id[i]};
    end
    input_force_valid = ch_valid;
  endtask

  // One cycle: apply inputs, predict and check the pop, update the model,
  // queue an expected readout, advance to the next falling edge.
  task automatic step();
    logic [NF-1:0] exp_ws;
    int g;
    drive();
    #1;
    exp_ws = '0;
    g = -1;
    if (!rd_en && ch_valid != '0) begin
      for (int k = 0; k < NF; k++) begin
        int idx;
        idx = (rr_ptr + k) % NF;
        if (g < 0 && ch_valid[idx]) g = idx;
      end
    end
    if (g >= 0) begin
      exp_ws[g] = 1'b1;
      rr_ptr = (g + 1) % NF;
      if (ch_tag[g]) begin
        for (int c = 0; c < 3; c++) mdl[ch_id[g]][c] = mdl[ch_id[g]][c] + ch_f[g][c];
      end
    end
    check("write_success", write_success, exp_ws);
    if (rd_en) begin
      exp_t e;
      e.cyc  = cyc + 1;
      e.data = {mdl[rd_addr][0], mdl[rd_addr][1], mdl[rd_addr][2]};
      sb_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic rd(input int a);
    rd_en   = 1'b1;
    rd_addr = IW'(a);
    step();
    rd_en   = 1'b0;
  endtask

  // Full zero-fill: expects 128 busy cycles; rd_en pulses inside CLEAR must be ignored.
  task automatic do_clear();
    int n;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    n = 0;
    while (busy && n < 300) begin
      rd_en   = ((n % 7) == 3);
      rd_addr = IW'($urandom);
      @(negedge clk);
      #1;
      n++;
    end
    rd_en = 1'b0;
    check("clear_cycles", n, 128);
    for (int a = 0; a < DEPTH; a++) for (int c = 0; c < 3; c++) mdl[a][c] = '0;
  endtask

  // Readout monitor: every rd_valid must match the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (rd_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_valid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("rd_latency", cyc, mon_e.cyc);
        check("rd_data", rd_data, mon_e.data);
      end
    end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      check("rd_valid_missing", rd_valid, 1'b1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; clear = 1'b0; rd_en = 1'b0; rd_addr = '0; rr_ptr = 0;
    for (int i = 0; i < NF; i++) begin
      ch_tag[i] = 1'b1; ch_id[i] = '0;
      for (int c = 0; c < 3; c++) ch_f[i][c] = '0;
    end
    ch_valid = '1;
    drive();
    repeat (3) @(negedge clk);
    #1;
    check("reset_write_success", write_success, '0);
    check("reset_rd_valid", rd_valid, 1'b0);
    check("reset_rd_data", rd_data, '0);
    check("reset_busy", busy, 1'b0);
    ch_valid = '0;
    drive();
    rst = 1'b1;
    @(negedge clk);

    // Zero-fill, then read back every address.
    do_clear();
    for (int a = 0; a < DEPTH; a++) rd(a);

    // Channels 0, 3, 6 continuously valid, id 5, force (1,2,3), 30 pops.
    for (int i = 0; i < NF; i++) begin
      ch_tag[i] = 1'b1; ch_id[i] = IW'(5);
      ch_f[i][0] = 32'd1; ch_f[i][1] = 32'd2; ch_f[i][2] = 32'd3;
    end
    ch_valid = 7'b1001001;
    repeat (30) step();
    ch_valid = '0;
    step();
    rd(5);

    // Back-to-back updates of one id from channel 2.
    ch_id[2] = IW'(9); ch_f[2][0] = 32'd7; ch_f[2][1] = 32'd0; ch_f[2][2] = 32'd0;
    ch_valid = 7'b0000100;
    repeat (10) step();
    ch_valid = '0;
    step();
    rd(9);

    // Two's-complement wrap.
    ch_id[1] = IW'(20); ch_f[1][0] = 32'h7FFF_FFFF; ch_f[1][1] = 32'd0; ch_f[1][2] = 32'd0;
    ch_valid = 7'b0000010;
    step();
    ch_f[1][0] = 32'd1;
    step();
    ch_valid = '0;
    step();
    rd(20);

    // Tag=0 entry is popped but leaves the cache untouched.
    ch_tag[4] = 1'b0; ch_id[4] = IW'(9); ch_f[4][0] = 32'd100;
    ch_valid = 7'b0010000;
    step();
    ch_valid = '0;
    step();
    rd(9);

    // rd_en held high with every channel valid: no pops.
    ch_valid = '1;
    rd_en = 1'b1;
    for (int n = 0; n < 8; n++) begin
      rd_addr = IW'($urandom_range(0, 9));
      step();
    end
    rd_en = 1'b0;
    ch_valid = '0;
    step();

    // Random traffic over a small id range to exercise forwarding.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NF; i++) begin
        ch_valid[i] = 1'($urandom_range(0, 1));
        ch_tag[i]   = ($urandom_range(0, 3) != 0);
        ch_id[i]    = IW'($urandom_range(0, 7));
        for (int c = 0; c < 3; c++) ch_f[i][c] = $urandom;
      end
      rd_en   = ($urandom_range(0, 3) == 0);
      rd_addr = IW'($urandom_range(0, 7));
      step();
    end
    rd_en = 1'b0;
    ch_valid = '0;
    step();
    for (int a = 0; a < 10; a++) rd(a);
    repeat (2) step();

    // Clear arriving while stage B is full is accepted one cycle later.
    ch_tag[0] = 1'b1; ch_id[0] = IW'(3);
    ch_valid = 7'b0000001;
    step();
    ch_valid = '0;
    drive();
    clear = 1'b1;
    #1;
    check("busy_stage_b_full", busy, 1'b1);
    @(negedge clk);
    clear = 1'b0;
    #1;
    check("busy_clear_deferred", busy, 1'b0);
    @(negedge clk);
    #1;
    check("busy_clear_entered", busy, 1'b1);
    repeat (20) @(negedge clk);
    rd_en = 1'b1;
    repeat (3) @(negedge clk);
    rd_en = 1'b0;
    #1;
    check("busy_mid_clear", busy, 1'b1);

    // Reset mid-clear aborts it immediately.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("busy_after_abort", busy, 1'b0);
    check("rd_valid_after_abort", rd_valid, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    check("busy_stays_idle", busy, 1'b0);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
